// File: rtl/multi_cycle_mips.sv
// Multi-cycle core for the 32-bit single-cycle encoding. An FSM steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB using req/ready memory ports.
module multi_cycle_mips #(
    parameter int          DATA_W   = 16,
    parameter int          PC_W     = 10,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              retire,
    output logic [PC_W-1:0]   retire_pc,
    output logic              halted,
    input  logic [3:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                           OP_LI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20,
                           F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
    localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic              imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] regs_q [16];

    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [5:0]        op, func;
    logic [3:0]        rs, rt, rd, shamt;
    logic [DATA_W-1:0] imm_s, imm_z, alu_y;
    logic              alu_ok;
    logic [PC_W-1:0]   pc_inc, br_tgt, jmp_tgt;
    logic              unused_ir;

    assign op        = ir_q[31:26];
    assign rs        = ir_q[25:22];
    assign rt        = ir_q[21:18];
    assign rd        = ir_q[17:14];
    assign shamt     = ir_q[13:10];
    assign func      = ir_q[9:4];
    assign imm_s     = DATA_W'($signed(ir_q[17:2]));
    assign imm_z     = DATA_W'(ir_q[17:2]);
    assign pc_inc    = pc_q + PC_W'(1);
    assign br_tgt    = pc_inc + PC_W'($signed(ir_q[11:2]));
    assign jmp_tgt   = PC_W'(ir_q[25:16]);
    assign unused_ir = ^ir_q[1:0];

    // alu_ok is low for anything that does not write a result in WB.
    always_comb begin
        alu_y  = '0;
        alu_ok = 1'b1;
        if (op == OP_RTYPE) begin
            case (func)
                F_ADD:   alu_y = a_q + b_q;
                F_SUB:   alu_y = a_q - b_q;
                F_AND:   alu_y = a_q & b_q;
                F_OR:    alu_y = a_q | b_q;
                F_SLT:   alu_y = DATA_W'($signed(a_q) < $signed(b_q));
                F_SLL:   alu_y = a_q << shamt;
                F_SRL:   alu_y = a_q >> shamt;
                default: alu_ok = 1'b0;
            endcase
        end else begin
            case (op)
                OP_ADDI: alu_y = a_q + imm_s;
                OP_ANDI: alu_y = a_q & imm_z;
                OP_ORI:  alu_y = a_q | imm_z;
                OP_LI:   alu_y = imm_z;
                default: alu_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        retire       = 1'b0;
        rf_we        = 1'b0;
        rf_waddr     = (op == OP_RTYPE) ? rd : rt;
        rf_wdata     = res_q;
        case (state_q)
            S_FETCH: if (imem_req_q && imem_ready) begin
                ir_d    = imem_rdata;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d     = regs_q[rs];
                b_d     = regs_q[rt];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op == OP_LW || op == OP_SW) begin
                    dmem_addr_d  = a_q + imm_s;
                    dmem_wdata_d = b_q;
                    dmem_we_d    = (op == OP_SW);
                    state_d      = S_MEM;
                end else if (alu_ok) begin
                    res_d   = alu_y;
                    state_d = S_WB;
                end else if (op == OP_HALT) begin
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    // Control transfers and undefined encodings commit here.
                    retire  = 1'b1;
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                    if (op == OP_RTYPE && func == F_JR) begin
                        pc_d = a_q[PC_W-1:0];
                    end else if (op == OP_J) begin
                        pc_d = jmp_tgt;
                    end else if (op == OP_JAL) begin
                        pc_d     = jmp_tgt;
                        rf_we    = 1'b1;
                        rf_waddr = 4'd15;
                        rf_wdata = DATA_W'(pc_inc);
                    end else if ((op == OP_BEQ && a_q == b_q) || (op == OP_BNE && a_q != b_q)) begin
                        pc_d = br_tgt;
                    end
                end
            end
            S_MEM: if (dmem_req_q && dmem_ready) begin
                dmem_we_d = 1'b0;
                if (dmem_we_q) begin
                    retire  = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end else begin
                    res_d   = dmem_rdata;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEM);
        halted_d   = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= PC_INIT;
            ir_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            halted_q     <= halted_d;
        end
    end

    // NOTE: the register file is cleared by reset, so it stays in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else if (rf_we && rf_waddr != 4'd0) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign retire_pc  = pc_q;
    assign halted     = halted_q;
    assign dbg_rdata  = regs_q[dbg_raddr];
endmodule

// File: tb/tb_multi_cycle_mips.sv
// Directed bench for multi_cycle_mips: behavioural wait-state memories, a
// retire_pc scoreboard queue and register checks through the debug port.
module tb_multi_cycle_mips;
    localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                           OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LI = 6'h0F,
                           OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [31:0] HALT_I = 32'hFC00_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst1_n = 1'b0;
    always #5 clk = ~clk;

    // DUT0: default parameters
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
    logic [9:0]  imem_addr, retire_pc;
    logic [31:0] imem_rdata;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata, dbg_rdata;
    logic [3:0]  dbg_raddr = 4'd0;

    multi_cycle_mips dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .retire(retire), .retire_pc(retire_pc), .halted(halted),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    // DUT1: 32-bit datapath, 12-bit PC
    logic        imem_req1, dmem_req1, dmem_we1, retire1, halted1;
    logic [11:0] imem_addr1, retire_pc1;
    logic [31:0] imem_rdata1, dmem_addr1, dmem_wdata1, dbg_rdata1;
    logic [3:0]  dbg_raddr1 = 4'd0;

    multi_cycle_mips #(.DATA_W(32), .PC_W(12), .RESET_PC(0)) dut1 (
        .clk(clk), .rst_n(rst1_n),
        .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ready(imem_req1), .imem_rdata(imem_rdata1),
        .dmem_req(dmem_req1), .dmem_we(dmem_we1), .dmem_addr(dmem_addr1), .dmem_wdata(dmem_wdata1),
        .dmem_ready(dmem_req1), .dmem_rdata(32'h0),
        .retire(retire1), .retire_pc(retire_pc1), .halted(halted1),
        .dbg_raddr(dbg_raddr1), .dbg_rdata(dbg_rdata1)
    );

    // Memory models with programmable wait states
    logic [31:0] imem0 [0:1023];
    logic [31:0] imem1 [0:4095];
    logic [15:0] dmem0 [0:255];
    int imem_delay = 0, dmem_delay = 0, icnt = 0, dcnt = 0, wr_cnt = 0;
    logic [15:0] last_wr_addr = '0, last_wr_data = '0;

    assign imem_ready  = imem_req && (icnt == imem_delay);
    assign imem_rdata  = imem0[imem_addr];
    assign imem_rdata1 = imem1[imem_addr1];
    assign dmem_ready  = dmem_req && (dcnt == dmem_delay);
    assign dmem_rdata  = dmem0[dmem_addr[7:0]];

    always @(posedge clk) begin
        icnt <= (!imem_req || imem_ready) ? 0 : icnt + 1;
        dcnt <= (!dmem_req || dmem_ready) ? 0 : dcnt + 1;
        if (dmem_req && dmem_ready && dmem_we) begin
            dmem0[dmem_addr[7:0]] <= dmem_wdata;
            last_wr_addr          <= dmem_addr;
            last_wr_data          <= dmem_wdata;
            wr_cnt                <= wr_cnt + 1;
        end
    end

    int n_cmp = 0, n_bad = 0;
    logic [9:0] exp_pc_q [$];
    bit sb_strict = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Retire scoreboard
    always @(negedge clk) begin
        if (rst_n && retire) begin
            if (sb_strict) check("retire_expected", 32'(exp_pc_q.size() > 0), 32'd1);
            if (exp_pc_q.size() > 0) check("retire_pc", 32'(retire_pc), 32'(exp_pc_q.pop_front()));
        end
    end

    function automatic logic [31:0] enc_r(input logic [5:0] func, input logic [3:0] rs, rt, rd, shamt);
        return {6'h00, rs, rt, rd, shamt, func, 4'h0};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [3:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm, 2'b00};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [9:0] tgt);
        return {op, tgt, 16'h0};
    endfunction

    task automatic start_prog();
        rst_n = 1'b0;
        exp_pc_q.delete();
        for (int i = 0; i < 1024; i++) imem0[i] = HALT_I;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 400) begin @(negedge clk); n++; end
        check(tag, 32'(halted), 32'd1);
    endtask

    task automatic wait_dreq(input string tag);
        int n = 0;
        while (!dmem_req && n < 100) begin @(negedge clk); n++; end
        check(tag, 32'(dmem_req), 32'd1);
    endtask

    task automatic reg_chk(input string tag, input logic [3:0] idx, input logic [15:0] exp);
        dbg_raddr = idx;
        #1;
        check(tag, 32'(dbg_rdata), 32'(exp));
    endtask

    task automatic fetch_scan(input string tag, input logic [9:0] addr);
        int fetches = 0, bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (imem_req) begin fetches++; if (imem_addr != addr) bad++; end
        end
        check({tag, "_fetches"}, 32'(fetches), 32'd10);
        check({tag, "_addr"}, 32'(bad), 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        // Reset state
        start_prog();
        #12;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_dmem_addr", 32'(dmem_addr), 32'd0);
        check("rst_dmem_wdata", 32'(dmem_wdata), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", 32'(imem_addr), 32'd0);

        // li/li/add/HALT, zero-wait, halt timing
        imem0[0] = enc_i(OP_LI, 4'd0, 4'd1, 16'd5);
        imem0[1] = enc_i(OP_LI, 4'd0, 4'd2, 16'd7);
        imem0[2] = enc_r(6'h20, 4'd1, 4'd2, 4'd3, 4'd0);
        exp_pc_q = '{10'd0, 10'd1, 10'd2, 10'd3};
        release_rst();
        n = 0;
        while (!imem_req && n < 10) begin @(negedge clk); n++; end
        check("first_fetch", 32'(imem_req), 32'd1);
        n = 0;
        while (!halted && n < 100) begin @(negedge clk); n++; end
        check("halt_cycle", 32'(n), 32'd15);
        reg_chk("add_r3", 4'd3, 16'd12);
        n = 0;
        repeat (10) begin @(negedge clk); if (imem_req || dmem_req || retire) n++; end
        check("post_halt_idle", 32'(n), 32'd0);
        check("t1_drain", 32'(exp_pc_q.size()), 32'd0);

        // ALU mix plus undefined op/func executing as NOP
        start_prog();
        imem0[0]  = enc_i(OP_LI, 4'd0, 4'd1, 16'h00FF);
        imem0[1]  = enc_i(OP_LI, 4'd0, 4'd2, 16'h0F0F);
        imem0[2]  = enc_r(6'h22, 4'd1, 4'd2, 4'd3, 4'd0);
        imem0[3]  = enc_r(6'h24, 4'd1, 4'd2, 4'd4, 4'd0);
        imem0[4]  = enc_r(6'h25, 4'd1, 4'd2, 4'd5, 4'd0);
        imem0[5]  = enc_r(6'h2A, 4'd3, 4'd1, 4'd6, 4'd0);
        imem0[6]  = enc_r(6'h02, 4'd3, 4'd0, 4'd7, 4'd4);
        imem0[7]  = enc_i(OP_ANDI, 4'd2, 4'd8, 16'hF00F);
        imem0[8]  = enc_i(OP_ORI, 4'd1, 4'd9, 16'h8000);
        imem0[9]  = enc_i(OP_ADDI, 4'd1, 4'd10, 16'hFFFE);
        imem0[10] = {6'h3E, 4'd1, 4'd5, 18'h0};
        imem0[11] = enc_r(6'h3F, 4'd1, 4'd2, 4'd5, 4'd0);
        imem0[12] = enc_r(6'h00, 4'd1, 4'd0, 4'd11, 4'd8);
        for (int i = 0; i < 14; i++) exp_pc_q.push_back(10'(i));
        release_rst();
        wait_halt("alu_halt");
        reg_chk("sub", 4'd3, 16'hF1F0);
        reg_chk("and", 4'd4, 16'h000F);
        reg_chk("or_nop_kept", 4'd5, 16'h0FFF);
        reg_chk("slt_signed", 4'd6, 16'h0001);
        reg_chk("srl_logical", 4'd7, 16'h0F1F);
        reg_chk("andi", 4'd8, 16'h000F);
        reg_chk("ori_zext", 4'd9, 16'h80FF);
        reg_chk("addi_neg", 4'd10, 16'h00FD);
        reg_chk("sll", 4'd11, 16'hFF00);
        check("alu_drain", 32'(exp_pc_q.size()), 32'd0);

        // sw/lw with three data wait states
        start_prog();
        dmem_delay = 3;
        imem0[0] = enc_i(OP_LI, 4'd0, 4'd1, 16'h0020);
        imem0[1] = enc_i(OP_LI, 4'd0, 4'd2, 16'hBEEF);
        imem0[2] = enc_i(OP_SW, 4'd1, 4'd2, 16'd4);
        imem0[3] = enc_i(OP_LW, 4'd1, 4'd4, 16'd4);
        exp_pc_q = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4};
        release_rst();
        wait_dreq("sw_req");
        check("sw_we", 32'(dmem_we), 32'd1);
        n = 0;
        while (dmem_req && n < 20) begin
            check("sw_addr_stable", 32'(dmem_addr), 32'h24);
            check("sw_wdata_stable", 32'(dmem_wdata), 32'hBEEF);
            n++;
            @(negedge clk);
        end
        check("sw_req_cycles", 32'(n), 32'd4);
        wait_dreq("lw_req");
        check("lw_we", 32'(dmem_we), 32'd0);
        n = 0;
        while (dmem_req && n < 20) begin
            check("lw_addr_stable", 32'(dmem_addr), 32'h24);
            n++;
            @(negedge clk);
        end
        check("lw_req_cycles", 32'(n), 32'd4);
        wait_halt("mem_halt");
        check("wr_count", 32'(wr_cnt), 32'd1);
        check("wr_addr", 32'(last_wr_addr), 32'h24);
        check("wr_data", 32'(last_wr_data), 32'hBEEF);
        reg_chk("lw_r4", 4'd4, 16'hBEEF);
        check("mem_drain", 32'(exp_pc_q.size()), 32'd0);

        // Async reset during a data wait
        start_prog();
        dmem_delay = 10;
        imem0[0] = enc_i(OP_LI, 4'd0, 4'd1, 16'h0020);
        imem0[1] = enc_i(OP_LW, 4'd1, 4'd4, 16'd4);
        exp_pc_q = '{10'd0};
        release_rst();
        wait_dreq("rst_mid_req");
        repeat (2) @(negedge clk);
        check("rst_mid_still_waiting", 32'(dmem_req), 32'd1);
        dbg_raddr = 4'd1;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_mid_dmem_addr", 32'(dmem_addr), 32'd0);
        check("rst_mid_imem_req", 32'(imem_req), 32'd0);
        check("rst_mid_r1", 32'(dbg_rdata), 32'd0);
        check("rst_mid_drain", 32'(exp_pc_q.size()), 32'd0);
        dmem_delay = 0;
        exp_pc_q = '{10'd0, 10'd1, 10'd2};
        release_rst();
        n = 0;
        while (!imem_req && n < 10) begin @(negedge clk); n++; end
        check("rst_mid_refetch", 32'(imem_addr), 32'd0);
        wait_halt("rst_mid_halt");
        reg_chk("rst_mid_lw", 4'd4, 16'hBEEF);

        // jal / jr / write to r0, with two fetch wait states
        start_prog();
        imem_delay = 2;
        imem0[0]     = enc_j(OP_J, 10'd8);
        imem0[8]     = enc_j(OP_JAL, 10'h100);
        imem0[10'h100] = enc_i(OP_LI, 4'd0, 4'd0, 16'd3);
        imem0[10'h101] = enc_r(6'h08, 4'd15, 4'd0, 4'd0, 4'd0);
        exp_pc_q = '{10'd0, 10'd8, 10'h100, 10'h101, 10'd9};
        release_rst();
        wait_halt("jal_halt");
        reg_chk("jal_r15", 4'd15, 16'd9);
        reg_chk("r0_zero", 4'd0, 16'd0);
        check("jal_drain", 32'(exp_pc_q.size()), 32'd0);
        imem_delay = 0;

        // beq r0,r0,-1 at PC 5 loops forever
        start_prog();
        sb_strict = 1'b0;
        imem0[0] = enc_j(OP_J, 10'd5);
        imem0[5] = enc_i(OP_BEQ, 4'd0, 4'd0, 16'h03FF);
        exp_pc_q = '{10'd0, 10'd5, 10'd5, 10'd5};
        release_rst();
        n = 0;
        while (exp_pc_q.size() > 0 && n < 100) begin @(negedge clk); n++; end
        check("beq_retires", 32'(exp_pc_q.size()), 32'd0);
        fetch_scan("beq_loop", 10'd5);
        check("beq_not_halted", 32'(halted), 32'd0);

        // bne not taken then taken with off10=0x3FF at PC 0
        start_prog();
        imem0[0] = enc_i(OP_BNE, 4'd1, 4'd0, 16'h03FF);
        imem0[1] = enc_i(OP_ADDI, 4'd0, 4'd1, 16'hFFFF);
        imem0[2] = enc_j(OP_J, 10'd0);
        exp_pc_q = '{10'd0, 10'd1, 10'd2, 10'd0, 10'd0, 10'd0};
        release_rst();
        n = 0;
        while (exp_pc_q.size() > 0 && n < 100) begin @(negedge clk); n++; end
        check("bne_retires", 32'(exp_pc_q.size()), 32'd0);
        fetch_scan("bne_loop", 10'd0);
        reg_chk("addi_m1", 4'd1, 16'hFFFF);

        // 32-bit datapath instance
        imem1[0] = enc_i(OP_LI, 4'd0, 4'd1, 16'hFFFF);
        imem1[1] = enc_r(6'h00, 4'd1, 4'd0, 4'd2, 4'd4);
        imem1[2] = enc_r(6'h2A, 4'd2, 4'd1, 4'd3, 4'd0);
        imem1[3] = enc_i(OP_ADDI, 4'd0, 4'd4, 16'hFFFF);
        imem1[4] = HALT_I;
        @(negedge clk);
        rst1_n = 1'b1;
        n = 0;
        while (!halted1 && n < 200) begin @(negedge clk); n++; end
        check("w32_halt", 32'(halted1), 32'd1);
        dbg_raddr1 = 4'd1; #1; check("w32_li_zext", dbg_rdata1, 32'h0000FFFF);
        dbg_raddr1 = 4'd2; #1; check("w32_sll", dbg_rdata1, 32'h000FFFF0);
        dbg_raddr1 = 4'd3; #1; check("w32_slt", dbg_rdata1, 32'h0);
        dbg_raddr1 = 4'd4; #1; check("w32_addi_sext", dbg_rdata1, 32'hFFFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multi_cycle_mips.md
Name: multi_cycle_mips

Overview:
- Parametrised multi-cycle successor to the single-cycle core. Same 32-bit instruction encoding; datapath width and PC width are configurable.
- An FSM sequences each instruction through fetch/decode/execute/memory/writeback.
- Instruction and data memories are external, each behind a req/ready handshake, so wait-state memories are supported.
- Adds r0 hardwired to zero, sign-extended branch offsets, HALT, a retire strobe and a debug register read port.

Parameters:
- DATA_W, 16, datapath and register width (16..32).
- PC_W, 10, PC and instruction-address width (10..16).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch word address.
- imem_ready  in  1  fetch complete; imem_rdata valid.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DATA_W  data word address.
- dmem_wdata  out  DATA_W  store data.
- dmem_ready  in  1  access complete; dmem_rdata valid for loads.
- dmem_rdata  in  DATA_W  load data.
- retire  out  1  one-cycle strobe: an instruction commits this cycle.
- retire_pc  out  PC_W  address of the committing instruction.
- halted  out  1  core has executed HALT.
- dbg_raddr  in  4  debug register index.
- dbg_rdata  out  DATA_W  combinational read of reg[dbg_raddr].

Behaviour:
- Fields:
  - op = [31:26], rs = [25:22], rt = [21:18], rd = [17:14], shamt = [13:10], func = [9:4].
  - imm16 = [17:2]; off10 = [11:2]; target = [25:16], zero-extended/truncated to PC_W.
- Register file: 16 x DATA_W. Reg 0 reads 0; writes to it are ignored.
- Immediates: sext(imm16) for addi/lw/sw; zext for andi/ori/li.
- Arithmetic: wraps modulo 2^DATA_W. slt is signed.
- R-type (op 0x00), result to rd:
  - func 0x20 add; 0x22 sub; 0x24 and; 0x25 or; 0x2A slt.
  - 0x00 sll (rs << shamt); 0x02 srl (rs >> shamt, logical).
  - 0x08 jr: PC = rs[PC_W-1:0].
- I/J-type, result to rt:
  - 0x08 addi; 0x0C andi; 0x0D ori; 0x0F li (rt = zext imm16).
  - 0x23 lw: rt = mem[rs + sext imm16].
  - 0x2B sw: mem[...] = rt.
  - 0x04 beq / 0x05 bne: taken PC = PC+1+sext(off10).
  - 0x02 j: PC = target.
  - 0x03 jal: r15 = PC+1 (zero-extended), PC = target.
  - 0x3F HALT.
- Undefined op or func: executes as NOP (retires, PC+1).
- FSM states and transitions:
  - FETCH: imem_req=1, imem_addr=PC. On imem_ready, latch IR -> DECODE.
  - DECODE: latch A = reg[rs], B = reg[rt] -> EXEC.
  - EXEC:
    - Branch, j, jal, jr, NOP: PC update, retire -> FETCH.
    - jal writes r15 in this cycle.
    - HALT: retire -> HALT state.
    - lw/sw -> MEM.
    - Otherwise latch ALU result -> WB.
  - MEM: dmem_req=1, address/wdata/we held stable.
    - On dmem_ready, sw retires -> FETCH.
    - On dmem_ready, lw latches data -> WB.
  - WB: register write, PC = PC+1, retire -> FETCH.
  - HALT: all requests low, halted=1. Only reset exits.
- Request rules:
  - req stays high with address/data stable until ready.
  - ready may be asserted in the same cycle as req (zero-wait).
  - ready while req is low is ignored.
- Latency with zero-wait memory:
  - ALU / li: 4 cycles.
  - Branch / jump / NOP: 3 cycles.
  - sw: 4 cycles. lw: 5 cycles.
  - Each wait cycle adds one.
- PC arithmetic wraps modulo 2^PC_W.
- retire is combinational from state plus completion, high for exactly one cycle per instruction. retire_pc = address of that instruction.
- A register written in WB is visible to the next instruction's DECODE; there are no hazards.
- dbg_rdata reflects a write on the cycle after the write edge.
- Reset (async, any state, including mid-handshake):
  - State -> FETCH, PC = RESET_PC, all registers = 0, IR = 0.
  - imem_req, dmem_req, dmem_we, retire, halted = 0 immediately.
  - dmem_addr, dmem_wdata = 0.
  - After release, the first fetch request is issued in the first clock cycle.

Test Plan:
- Zero-wait program `li r1,5; li r2,7; add r3,r1,r2; HALT` -> r3=12. retire_pc sequence 0,1,2,3. halted=1 at cycle 15; no requests afterwards.
- `li r1,0x20; li r2,0xBEEF; sw r2,4(r1); lw r4,4(r1)` with dmem_ready delayed 3 cycles -> dmem_addr=0x24 held stable for 4 cycles, write of 0xBEEF, r4=0xBEEF.
- `beq r0,r0,-1` at PC 5 -> next fetch at 5, infinite loop. bne taken with off10=0x3FF at PC 0 -> PC wraps to 0. `addi r1,r0,-1` -> r1=0xFFFF.
- `jal 0x100` at PC 8 -> r15=9, next fetch 0x100. `jr r15` -> fetch 9. `li r0,3` -> dbg read of r0 returns 0.
- Assert rst_n low during a MEM wait -> dmem_req drops without a clock edge, registers clear, and after release fetch restarts at RESET_PC.
- DATA_W=32, PC_W=12: `li r1,0xFFFF; sll r2,r1,4` -> r2=0x000FFFF0. `slt r3,r2,r1` -> r3=0.
